// File: rtl/mem_router.sv
// rtl/mem_router.sv - address-window router from one memory master to NSLV slaves
// Registered request fields and completion outputs; one transaction in flight at a time.
module mem_router #(
    parameter int                NSLV     = 4,
    parameter logic [NSLV*32-1:0] SLV_BASE = {32'h0, 32'h2000000, 32'h1000000, 32'h100000},
    parameter logic [NSLV*32-1:0] SLV_TOP  = {32'h100000, 32'h200C000, 32'h1000008, 32'h200000},
    parameter int                TIMEOUT  = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 memory_valid,
    input  logic                 memory_instr,
    input  logic [31:0]          memory_addr,
    input  logic [31:0]          memory_wdata,
    input  logic [3:0]           memory_wstrb,
    output logic [31:0]          memory_rdata,
    output logic                 memory_ready,
    output logic                 memory_error,
    output logic [NSLV-1:0]      slv_valid,
    output logic                 slv_instr,
    output logic [31:0]          slv_addr,
    output logic [31:0]          slv_wdata,
    output logic [3:0]           slv_wstrb,
    input  logic [NSLV*32-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ready
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [NSLV-1:0]   slv_valid_q, slv_valid_d;
    logic              slv_instr_q, slv_instr_d;
    logic [31:0]       slv_addr_q, slv_addr_d;
    logic [31:0]       slv_wdata_q, slv_wdata_d;
    logic [3:0]        slv_wstrb_q, slv_wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;

    logic              hit;
    logic [SW-1:0]     hit_idx;
    logic [31:0]       hit_off;
    logic              sel_ready;
    logic [31:0]       sel_rdata;

    // Scan from the top index down so the lowest matching window wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (memory_addr >= SLV_BASE[32*i +: 32] && memory_addr < SLV_TOP[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
                hit_off = memory_addr - SLV_BASE[32*i +: 32];
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SW'(i)) begin
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        slv_valid_d = '0;
        slv_instr_d = slv_instr_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        slv_wstrb_d = slv_wstrb_q;
        rdata_d     = '0;
        ready_d     = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (memory_valid) begin
                    if (hit) begin
                        sel_d       = hit_idx;
                        cnt_d       = '0;
                        slv_instr_d = memory_instr;
                        slv_addr_d  = hit_off;
                        slv_wdata_d = memory_wdata;
                        slv_wstrb_d = memory_wstrb;
                        for (int i = 0; i < NSLV; i++) begin
                            slv_valid_d[i] = (hit_idx == SW'(i));
                        end
                        state_d     = BUSY;
                    end else begin
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            slv_valid_q <= '0;
            slv_instr_q <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_wstrb_q <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            slv_valid_q <= slv_valid_d;
            slv_instr_q <= slv_instr_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            slv_wstrb_q <= slv_wstrb_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign memory_rdata = rdata_q;
    assign memory_ready = ready_q;
    assign memory_error = error_q;
    assign slv_valid    = slv_valid_q;
    assign slv_instr    = slv_instr_q;
    assign slv_addr     = slv_addr_q;
    assign slv_wdata    = slv_wdata_q;
    assign slv_wstrb    = slv_wstrb_q;

endmodule

// File: tb/tb_mem_router.sv
// tb/tb_mem_router.sv - directed self-checking bench for mem_router
module tb_mem_router;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          memory_valid = 1'b0;
    logic          memory_instr = 1'b0;
    logic [31:0]   memory_addr  = '0;
    logic [31:0]   memory_wdata = '0;
    logic [3:0]    memory_wstrb = '0;
    logic [31:0]   memory_rdata;
    logic          memory_ready;
    logic          memory_error;
    logic [3:0]    slv_valid;
    logic          slv_instr;
    logic [31:0]   slv_addr;
    logic [31:0]   slv_wdata;
    logic [3:0]    slv_wstrb;
    logic [127:0]  slv_rdata = '0;
    logic [3:0]    slv_ready = '0;

    int n_checks = 0;
    int n_errors = 0;

    // slot3..slot0; window 0 sits inside window 1 to exercise lowest-index priority
    mem_router #(
        .NSLV     (4),
        .SLV_BASE ({32'h0010_0000, 32'h0100_0000, 32'h0200_0000, 32'h0200_B000}),
        .SLV_TOP  ({32'h0020_0000, 32'h0100_0008, 32'h0200_C000, 32'h0200_C000}),
        .TIMEOUT  (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready),
        .memory_error (memory_error),
        .slv_valid    (slv_valid),
        .slv_instr    (slv_instr),
        .slv_addr     (slv_addr),
        .slv_wdata    (slv_wdata),
        .slv_wstrb    (slv_wstrb),
        .slv_rdata    (slv_rdata),
        .slv_ready    (slv_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        memory_valid = 1'b1;
        memory_addr  = addr;
        memory_wdata = wdata;
        memory_wstrb = wstrb;
        tick();
        memory_valid = 1'b0;
        memory_addr  = '0;
        memory_wdata = '0;
        memory_wstrb = '0;
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_ready"}, {31'd0, memory_ready}, 32'd0);
        chk({tag, "_error"}, {31'd0, memory_error}, 32'd0);
        chk({tag, "_rdata"}, memory_rdata, 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, memory_ready}, 32'd0);
        chk("rst_valid", {28'd0, slv_valid}, 32'd0);
        chk("rst_addr", slv_addr, 32'd0);
        tick();
        tick();

        // Release reset and request in the very same cycle
        reset = 1'b1;
        chk_idle_out("rel");
        issue(32'h0200_0004, 32'd0, 4'h0);
        chk("a_valid", {28'd0, slv_valid}, 32'h2);
        chk("a_addr", slv_addr, 32'h4);
        chk("a_ready_t1", {31'd0, memory_ready}, 32'd0);
        slv_ready = 4'b0010;
        slv_rdata[63:32] = 32'hDEAD_BEEF;
        tick();
        slv_ready = '0;
        chk("a_ready_t2", {31'd0, memory_ready}, 32'd1);
        chk("a_error", {31'd0, memory_error}, 32'd0);
        chk("a_rdata", memory_rdata, 32'hDEAD_BEEF);
        chk("a_valid_t2", {28'd0, slv_valid}, 32'd0);
        tick();
        chk_idle_out("a_after");

        // Write with three wait cycles
        issue(32'h0100_0000, 32'h41, 4'hF);
        chk("b_valid", {28'd0, slv_valid}, 32'h4);
        chk("b_addr", slv_addr, 32'h0);
        chk("b_wdata", slv_wdata, 32'h41);
        chk("b_wstrb", {28'd0, slv_wstrb}, 32'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_wait_ready", {31'd0, memory_ready}, 32'd0);
            chk("b_wait_valid", {28'd0, slv_valid}, 32'd0);
            chk("b_hold_wdata", slv_wdata, 32'h41);
        end
        slv_ready = 4'b0100;
        slv_rdata[95:64] = 32'h1234_5678;
        tick();
        slv_ready = '0;
        chk("b_ready", {31'd0, memory_ready}, 32'd1);
        chk("b_error", {31'd0, memory_error}, 32'd0);
        chk("b_rdata", memory_rdata, 32'h1234_5678);
        tick();

        // Unmapped and exclusive-top decode errors
        slv_rdata = {4{32'hFFFF_FFFF}};
        issue(32'h8000_0000, 32'd0, 4'h0);
        chk("c_valid", {28'd0, slv_valid}, 32'd0);
        chk("c_ready", {31'd0, memory_ready}, 32'd1);
        chk("c_error", {31'd0, memory_error}, 32'd1);
        chk("c_rdata", memory_rdata, 32'd0);
        tick();
        chk_idle_out("c_after");
        issue(32'h0100_0008, 32'd0, 4'h0);
        chk("top_valid", {28'd0, slv_valid}, 32'd0);
        chk("top_error", {31'd0, memory_error}, 32'd1);
        tick();
        issue(32'h0100_0007, 32'd0, 4'h0);
        chk("last_valid", {28'd0, slv_valid}, 32'h4);
        chk("last_addr", slv_addr, 32'h7);
        slv_ready = 4'b0100;
        slv_rdata[95:64] = 32'h0000_0777;
        tick();
        slv_ready = '0;
        chk("last_rdata", memory_rdata, 32'h0000_0777);
        tick();

        // Timeout on slave 0 while another slave strobes ready
        issue(32'h0200_B000, 32'd0, 4'h0);
        chk("t_valid", {28'd0, slv_valid}, 32'h1);
        slv_ready = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t_wait_ready", {31'd0, memory_ready}, 32'd0);
        end
        tick();
        slv_ready = '0;
        chk("t_ready", {31'd0, memory_ready}, 32'd1);
        chk("t_error", {31'd0, memory_error}, 32'd1);
        chk("t_rdata", memory_rdata, 32'd0);
        slv_ready = 4'b0001;
        tick();
        slv_ready = '0;
        chk_idle_out("t_late1");
        tick();
        chk_idle_out("t_late2");

        // Overlap: slave 0 wins; slave 1 ready and new requests during BUSY ignored
        slv_rdata = '0;
        issue(32'h0200_B010, 32'd0, 4'h0);
        chk("o_valid", {28'd0, slv_valid}, 32'h1);
        chk("o_addr", slv_addr, 32'h10);
        slv_ready = 4'b0010;
        slv_rdata[63:32] = 32'hBAD0_0001;
        memory_valid = 1'b1;
        memory_addr  = 32'h8000_0000;
        tick();
        memory_valid = 1'b0;
        memory_addr  = '0;
        chk("o_ign_ready", {31'd0, memory_ready}, 32'd0);
        chk("o_ign_valid", {28'd0, slv_valid}, 32'd0);
        slv_ready = 4'b0001;
        slv_rdata[31:0] = 32'hCAFE_0001;
        tick();
        slv_ready = '0;
        chk("o_ready", {31'd0, memory_ready}, 32'd1);
        chk("o_rdata", memory_rdata, 32'hCAFE_0001);
        tick();

        // Reset while a transaction is in flight
        issue(32'h0015_0000, 32'h55, 4'h3);
        chk("r_valid", {28'd0, slv_valid}, 32'h8);
        chk("r_addr", slv_addr, 32'h0005_0000);
        reset = 1'b0;
        #1;
        chk("r_valid0", {28'd0, slv_valid}, 32'd0);
        chk("r_addr0", slv_addr, 32'd0);
        chk("r_wstrb0", {28'd0, slv_wstrb}, 32'd0);
        chk_idle_out("r_in");
        tick();
        reset = 1'b1;
        slv_ready = 4'b1000;
        slv_rdata[127:96] = 32'h7777_7777;
        tick();
        slv_ready = '0;
        chk_idle_out("r_stale1");
        tick();
        chk_idle_out("r_stale2");
        issue(32'h0015_0004, 32'd0, 4'h0);
        chk("r_new_valid", {28'd0, slv_valid}, 32'h8);
        tick();
        chk("r_new_wait", {31'd0, memory_ready}, 32'd0);
        slv_ready = 4'b1000;
        slv_rdata[127:96] = 32'h0BAD_F00D;
        tick();
        slv_ready = '0;
        chk("r_new_ready", {31'd0, memory_ready}, 32'd1);
        chk("r_new_error", {31'd0, memory_error}, 32'd0);
        chk("r_new_rdata", memory_rdata, 32'h0BAD_F00D);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_router.md
MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 Parameter NSLV, default 4: number of slave windows, 1..16.
REQ-002 Parameter SLV_BASE, default {32'h0,32'h2000000,32'h1000000,32'h100000}: NSLV*32 packed window base addresses; slot i = bits [32*i+31:32*i].
REQ-003 Parameter SLV_TOP, default {32'h100000,32'h200C000,32'h1000008,32'h200000}: NSLV*32 packed exclusive window top addresses.
REQ-004 Parameter TIMEOUT, default 1024: cycles BUSY waits for slave ready before error completion; >=2.
REQ-005 clock  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
REQ-007 memory_valid  in  1  master request strobe, one cycle per request.
REQ-008 memory_instr  in  1  instruction-fetch qualifier.
REQ-009 memory_addr  in  32  absolute byte address.
REQ-010 memory_wdata  in  32  write data.
REQ-011 memory_wstrb  in  4  byte strobes; 0 = read.
REQ-012 memory_rdata  out  32  read data, valid with memory_ready.
REQ-013 memory_ready  out  1  one-cycle completion pulse.
REQ-014 memory_error  out  1  completion was decode error or timeout; valid with memory_ready.
REQ-015 slv_valid  out  NSLV  one-hot request pulse per slave.
REQ-016 slv_instr/slv_addr/slv_wdata/slv_wstrb  out  1/32/32/4  shared request fields; slv_addr = offset from selected window base.
REQ-017 slv_rdata  in  NSLV*32  per-slave read data, slot i = [32*i+31:32*i].
REQ-018 slv_ready  in  NSLV  per-slave completion.

Function
REQ-019 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-020 Decode: hit i when SLV_BASE[i] <= memory_addr < SLV_TOP[i]; overlapping hits resolve to lowest index.
REQ-021 IDLE + memory_valid + hit i: register sel=i, offset=memory_addr-SLV_BASE[i] (32-bit wrap), instr/wdata/wstrb; next cycle slv_valid[i]=1 for exactly one cycle; go BUSY.
REQ-022 IDLE + memory_valid + no hit: no slv_valid; next cycle memory_ready=1, memory_error=1, memory_rdata=0; stay IDLE.
REQ-023 slv_instr/addr/wdata/wstrb hold registered values from issue until completion.
REQ-024 BUSY: slv_ready[sel]=1 (permitted in the slv_valid cycle) -> capture slv_rdata[sel], go RESP.
REQ-025 RESP: memory_ready=1, memory_error=0, memory_rdata=captured data for one cycle; go IDLE.
REQ-026 Latency: request cycle t, slave ready cycle t+1+k -> memory_ready at t+2+k; minimum 2.
REQ-027 BUSY timeout counter starts at 0 on entry, increments each cycle without slv_ready[sel]; on reaching TIMEOUT-1: next cycle memory_ready=1, memory_error=1, memory_rdata=0, go IDLE.
REQ-028 slv_ready from non-selected slaves, and any slv_ready in IDLE/RESP, is ignored.
REQ-029 memory_valid in BUSY or RESP is ignored; no queueing.
REQ-030 memory_ready/memory_error/memory_rdata are 0 in all cycles without a completion.
REQ-031 At most one slv_valid bit asserted in any cycle.

Reset
REQ-032 reset==0: state IDLE, sel=0, counter=0, all outputs 0, in-flight transaction discarded without completion.
REQ-033 Outputs remain 0 in the first cycle after reset release; a request in that cycle is accepted normally.

Verification
REQ-034 Read 0x02000004, slave 1 ready with 0xDEADBEEF in the slv_valid cycle -> slv_valid=4'b0010, slv_addr=0x4, memory_ready at t+2, rdata 0xDEADBEEF, error 0.
REQ-035 Write 0x01000000, wstrb 4'hF, wdata 0x41; slave 2 ready after 3 wait cycles -> memory_ready at t+5, error 0, rdata = slave's returned value.
REQ-036 Access 0x80000000 (unmapped) -> no slv_valid; memory_ready=1, error=1, rdata=0 at t+1.
REQ-037 TIMEOUT=8, slave 0 never ready -> memory_ready=1, error=1 exactly 8 cycles after slv_valid; later slv_ready[0] produces no completion.
REQ-038 reset low while BUSY -> all outputs 0 immediately; after release, slv_ready[sel] gives no completion; new request completes normally.
REQ-039 Overlapping windows 0 and 1 both containing the address -> slave 0 selected; slv_ready[1] during BUSY ignored.
